// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment mapping for the seven-segment display blocks.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Entry n is the pattern for hex digit n; the highest entry is listed first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment pattern decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = hex2seg(i_nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode display driver with per-frame snapshot
// of the display word, decimal points and leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_DIGIT - 1);

  logic [CNT_W-1:0] r_pcnt;
  logic [2:0]       r_idx;
  logic [31:0]      r_snap;
  logic [7:0]       r_dpm;
  logic             r_lz;
  logic [7:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_fs;

  logic             w_tick;
  logic             w_frame;
  logic [2:0]       w_k;
  logic [31:0]      w_src;
  logic [7:0]       w_dpm;
  logic             w_lz;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg;
  logic             w_blank;

  assign w_tick  = (r_pcnt == LAST);
  // idx resets to 7, so the first tick after reset is a normal 7->0 wrap.
  assign w_frame = w_tick && (r_idx == 3'd7);
  assign w_k     = r_idx + 3'd1;

  // On a frame boundary digit 0 is drawn straight from the incoming inputs.
  assign w_src   = w_frame ? data     : r_snap;
  assign w_dpm   = w_frame ? dp_mask  : r_dpm;
  assign w_lz    = w_frame ? blank_lz : r_lz;

  assign w_nib   = w_src[{w_k, 2'b00} +: 4];
  assign w_blank = w_lz && (w_k != 3'd0) && ((w_src >> {w_k, 2'b00}) == 32'd0);

  seg7_hex_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_idx  <= 3'd7;
      r_snap <= '0;
      r_dpm  <= '0;
      r_lz   <= 1'b0;
      r_an   <= AN_OFF;
      r_seg  <= SEG_OFF;
      r_dp   <= 1'b1;
      r_fs   <= 1'b0;
    end else begin
      r_fs <= w_frame;
      if (w_tick) begin
        r_pcnt <= '0;
        r_idx  <= w_k;
        if (w_frame) begin
          r_snap <= data;
          r_dpm  <= dp_mask;
          r_lz   <= blank_lz;
        end
        r_an  <= w_blank ? AN_OFF  : ~(8'(1) << w_k);
        r_seg <= w_blank ? SEG_OFF : w_seg;
        r_dp  <= ~w_dpm[w_k];
      end else begin
        r_pcnt <= r_pcnt + 1'b1;
      end
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a timeline model: display state is
// derived from the number of clock edges since reset release and an input history.
module tb_seg7_scan_driver;

  localparam int TPD   = 4;
  localparam int FRAME = 8 * TPD;
  localparam int HMAX  = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = 32'h0;
  logic [7:0]  dp_mask = 8'h0;
  logic        blank_lz = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  always #5 clk = ~clk;

  seg7_scan_driver #(.TICKS_PER_DIGIT(TPD), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .dp_mask     (dp_mask),
    .blank_lz    (blank_lz),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  int total = 0;
  int bad   = 0;
  int e     = 0;

  logic [31:0] h_data [HMAX];
  logic [7:0]  h_dpm  [HMAX];
  logic        h_lz   [HMAX];
  logic [6:0]  pat    [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, e, got, exp);
    end
  endtask

  function automatic int cur_digit();
    if (e < TPD) return -1;
    return ((e / TPD) - 1) % 8;
  endfunction

  task automatic compare();
    logic [7:0]  ean;
    logic [6:0]  eseg;
    logic        edp, efs, blank;
    logic [31:0] sd;
    logic [3:0]  nib;
    int s, k, b;
    if (e < TPD) begin
      ean = 8'hFF; eseg = 7'h7F; edp = 1'b1; efs = 1'b0;
    end else begin
      s  = e / TPD - 1;
      k  = s % 8;
      b  = TPD + FRAME * (s / 8);
      sd = h_data[b];
      blank = h_lz[b] && (k != 0);
      for (int j = k; j < 8; j++)
        if (sd[4*j +: 4] != 4'h0) blank = 1'b0;
      nib  = sd[4*k +: 4];
      ean  = blank ? 8'hFF : ~(8'h01 << k);
      eseg = blank ? 7'h7F : pat[nib];
      edp  = ~h_dpm[b][k];
      efs  = ((e - TPD) % FRAME) == 0;
    end
    chk("an", 32'(an), 32'(ean));
    chk("seg", 32'(seg), 32'(eseg));
    chk("dp", 32'(dp), 32'(edp));
    chk("frame_start", 32'(frame_start), 32'(efs));
    chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic step();
    if (e + 1 >= HMAX) begin
      chk("hist_overflow", 32'(e), 32'(HMAX - 2));
      $fatal(1, "history overflow");
    end
    h_data[e+1] = data;
    h_dpm[e+1]  = dp_mask;
    h_lz[e+1]   = blank_lz;
    @(posedge clk);
    e++;
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_digit(input int d);
    int guard = 0;
    while (cur_digit() != d && guard < 4 * FRAME) begin
      step();
      guard++;
    end
    chk("wait_digit", 32'(cur_digit()), 32'(d));
  endtask

  // Assert reset between edges and confirm the outputs go dark without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_fs", 32'(frame_start), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    compare();
  endtask

  initial begin
    pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    data = 32'h89AB_CDEF; dp_mask = 8'h00; blank_lz = 1'b0;
    do_reset();
    run(TPD + FRAME + 4);

    data = 32'h1111_1111;
    run(FRAME);
    wait_digit(3);
    data = 32'h2222_2222;
    run(FRAME + 4);

    data = 32'h0000_0A05; blank_lz = 1'b1; dp_mask = 8'h10;
    run(2 * FRAME);

    data = 32'h0; dp_mask = 8'h00; blank_lz = 1'b1;
    run(2 * FRAME + 4);

    data = 32'h1234_5678; dp_mask = 8'hA5; blank_lz = 1'b0;
    run(FRAME);
    wait_digit(5);
    do_reset();
    run(TPD + FRAME);

    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 7) == 0) data = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) dp_mask = 8'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
